// File: rtl/tank_shot_ctrl.sv
// Two-player projectile controller: per-shooter launch/fly/cooldown FSM, frame-rate motion,
// axis-aligned hit detection against the opposing tank, saturating hit scores.
module tank_shot_ctrl #(
  parameter int BALL_S   = 4,
  parameter int TANK_S   = 16,
  parameter int SPEED    = 4,
  parameter int COOLDOWN = 30,
  parameter int X_MAX    = 639,
  parameter int Y_MAX    = 479
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic       fire1,
  input  logic       fire2,
  input  logic [1:0] dir1,
  input  logic [1:0] dir2,
  input  logic [9:0] TankX1,
  input  logic [9:0] TankY1,
  input  logic [9:0] TankX2,
  input  logic [9:0] TankY2,
  output logic [9:0] BallX1,
  output logic [9:0] BallY1,
  output logic [9:0] BallX2,
  output logic [9:0] BallY2,
  output logic       ball_fire1,
  output logic       ball_fire2,
  output logic       hit1,
  output logic       hit2,
  output logic [3:0] score1,
  output logic [3:0] score2
);

  typedef enum logic [1:0] {IDLE, FLY, COOL} state_t;

  localparam logic signed [10:0] STEP  = 11'(SPEED);
  localparam logic signed [10:0] LO    = 11'(BALL_S);
  localparam logic signed [10:0] XHI   = 11'(X_MAX - BALL_S);
  localparam logic signed [10:0] YHI   = 11'(Y_MAX - BALL_S);
  localparam logic [11:0]        REACH = 12'(TANK_S / 2 + BALL_S);
  localparam logic [4:0]         CINIT = 5'(COOLDOWN);

  logic frame_d;
  logic tick;

  logic       fire   [2];
  logic [1:0] dir    [2];
  logic [9:0] tank_x [2];
  logic [9:0] tank_y [2];

  assign fire[0]   = fire1;
  assign fire[1]   = fire2;
  assign dir[0]    = dir1;
  assign dir[1]    = dir2;
  assign tank_x[0] = TankX1;
  assign tank_x[1] = TankX2;
  assign tank_y[0] = TankY1;
  assign tank_y[1] = TankY2;

  always_ff @(posedge Clk) begin
    if (Reset) frame_d <= 1'b0;
    else       frame_d <= frame_clk;
  end

  assign tick = frame_clk & ~frame_d;

  for (genvar g = 0; g < 2; g++) begin : g_shot
    localparam int O = 1 - g;

    state_t            state, state_nx;
    logic              fire_prev, fire_prev_nx;
    logic [1:0]        dir_lat, dir_lat_nx;
    logic [4:0]        cool_cnt, cool_cnt_nx;
    logic [9:0]        ball_x, ball_x_nx, ball_y, ball_y_nx;
    logic              ball_on, ball_on_nx;
    logic              strike, strike_nx;
    logic [3:0]        score, score_nx;
    logic signed [10:0] px, py, nx, ny;
    logic signed [11:0] dx, dy;
    logic [11:0]        adx, ady;
    logic               hit_det, wall_det;

    // 12-bit distance keeps |nx - tank| exact even when nx has stepped below zero
    always_comb begin
      px = $signed({1'b0, ball_x});
      py = $signed({1'b0, ball_y});
      nx = px;
      ny = py;
      case (dir_lat)
        2'd0:    ny = py - STEP;
        2'd1:    nx = px + STEP;
        2'd2:    ny = py + STEP;
        default: nx = px - STEP;
      endcase
      dx       = {nx[10], nx} - {2'b00, tank_x[O]};
      dy       = {ny[10], ny} - {2'b00, tank_y[O]};
      adx      = dx[11] ? -dx : dx;
      ady      = dy[11] ? -dy : dy;
      hit_det  = (adx < REACH) && (ady < REACH);
      wall_det = (nx < LO) || (nx > XHI) || (ny < LO) || (ny > YHI);
    end

    always_comb begin
      state_nx     = state;
      fire_prev_nx = fire_prev;
      dir_lat_nx   = dir_lat;
      cool_cnt_nx  = cool_cnt;
      ball_x_nx    = ball_x;
      ball_y_nx    = ball_y;
      ball_on_nx   = ball_on;
      strike_nx    = 1'b0;
      score_nx     = score;
      if (tick) begin
        fire_prev_nx = fire[g];
        case (state)
          IDLE: begin
            if (fire[g] && !fire_prev) begin
              state_nx   = FLY;
              ball_x_nx  = tank_x[g];
              ball_y_nx  = tank_y[g];
              dir_lat_nx = dir[g];
              ball_on_nx = 1'b1;
            end
          end
          FLY: begin
            if (hit_det) begin
              strike_nx   = 1'b1;
              score_nx    = (score == 4'd15) ? score : score + 4'd1;
              ball_on_nx  = 1'b0;
              cool_cnt_nx = CINIT;
              state_nx    = COOL;
            end else if (wall_det) begin
              ball_on_nx  = 1'b0;
              cool_cnt_nx = CINIT;
              state_nx    = COOL;
            end else begin
              ball_x_nx = nx[9:0];
              ball_y_nx = ny[9:0];
            end
          end
          COOL: begin
            cool_cnt_nx = cool_cnt - 5'd1;
            if (cool_cnt <= 5'd1) state_nx = IDLE;
          end
          default: state_nx = IDLE;
        endcase
      end
    end

    always_ff @(posedge Clk) begin
      if (Reset) begin
        state     <= IDLE;
        fire_prev <= 1'b0;
        dir_lat   <= '0;
        cool_cnt  <= '0;
        ball_x    <= '0;
        ball_y    <= '0;
        ball_on   <= 1'b0;
        strike    <= 1'b0;
        score     <= '0;
      end else begin
        state     <= state_nx;
        fire_prev <= fire_prev_nx;
        dir_lat   <= dir_lat_nx;
        cool_cnt  <= cool_cnt_nx;
        ball_x    <= ball_x_nx;
        ball_y    <= ball_y_nx;
        ball_on   <= ball_on_nx;
        strike    <= strike_nx;
        score     <= score_nx;
      end
    end
  end

  // strike is raised by the shooter, so each hit output comes from the opposing shooter
  assign BallX1     = g_shot[0].ball_x;
  assign BallY1     = g_shot[0].ball_y;
  assign BallX2     = g_shot[1].ball_x;
  assign BallY2     = g_shot[1].ball_y;
  assign ball_fire1 = g_shot[0].ball_on;
  assign ball_fire2 = g_shot[1].ball_on;
  assign hit1       = g_shot[1].strike;
  assign hit2       = g_shot[0].strike;
  assign score1     = g_shot[0].score;
  assign score2     = g_shot[1].score;

endmodule

// File: tb/tb_tank_shot_ctrl.sv
// Bench for tank_shot_ctrl: directed scenarios with literal expectations plus a randomized
// run compared every cycle against a tick-level behavioural model.
module tb_tank_shot_ctrl;
  localparam int BALL_S   = 4;
  localparam int TANK_S   = 16;
  localparam int SPEED    = 4;
  localparam int COOLDOWN = 30;
  localparam int X_MAX    = 639;
  localparam int Y_MAX    = 479;

  logic       Clk = 1'b0;
  logic       Reset, frame_clk, fire1, fire2;
  logic [1:0] dir1, dir2;
  logic [9:0] TankX1, TankY1, TankX2, TankY2;
  logic [9:0] BallX1, BallY1, BallX2, BallY2;
  logic       ball_fire1, ball_fire2, hit1, hit2;
  logic [3:0] score1, score2;

  tank_shot_ctrl #(
    .BALL_S(BALL_S), .TANK_S(TANK_S), .SPEED(SPEED),
    .COOLDOWN(COOLDOWN), .X_MAX(X_MAX), .Y_MAX(Y_MAX)
  ) dut (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk),
    .fire1(fire1), .fire2(fire2), .dir1(dir1), .dir2(dir2),
    .TankX1(TankX1), .TankY1(TankY1), .TankX2(TankX2), .TankY2(TankY2),
    .BallX1(BallX1), .BallY1(BallY1), .BallX2(BallX2), .BallY2(BallY2),
    .ball_fire1(ball_fire1), .ball_fire2(ball_fire2),
    .hit1(hit1), .hit2(hit2), .score1(score1), .score2(score2)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int passes = 0;
  bit cmp_en = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  // Model: a shot is either flying (m_on), locked out (m_lock ticks left) or ready.
  int m_on[2], m_x[2], m_y[2], m_dir[2], m_lock[2], m_fprev[2], m_score[2], m_struck[2];
  int m_frame_prev = 0;

  always @(posedge Clk) begin : p_model
    int tx[2], ty[2], fr[2], dr[2];
    int nx, ny, o;
    bit tk;
    tx = '{int'(TankX1), int'(TankX2)};
    ty = '{int'(TankY1), int'(TankY2)};
    fr = '{int'(fire1), int'(fire2)};
    dr = '{int'(dir1), int'(dir2)};
    m_struck = '{0, 0};
    if (Reset) begin
      m_frame_prev = 0;
      for (int n = 0; n < 2; n++) begin
        m_on[n] = 0; m_x[n] = 0; m_y[n] = 0; m_dir[n] = 0;
        m_lock[n] = 0; m_fprev[n] = 0; m_score[n] = 0;
      end
    end else begin
      tk = frame_clk && (m_frame_prev == 0);
      m_frame_prev = int'(frame_clk);
      if (tk) begin
        for (int n = 0; n < 2; n++) begin
          bit launch;
          launch = (fr[n] == 1) && (m_fprev[n] == 0);
          m_fprev[n] = fr[n];
          o = 1 - n;
          if (m_on[n] != 0) begin
            nx = m_x[n] + ((m_dir[n] == 1) ? SPEED : (m_dir[n] == 3) ? -SPEED : 0);
            ny = m_y[n] + ((m_dir[n] == 2) ? SPEED : (m_dir[n] == 0) ? -SPEED : 0);
            if (iabs(nx - tx[o]) < TANK_S / 2 + BALL_S && iabs(ny - ty[o]) < TANK_S / 2 + BALL_S) begin
              m_struck[o] = 1;
              if (m_score[n] < 15) m_score[n]++;
              m_on[n] = 0;
              m_lock[n] = COOLDOWN;
            end else if (nx < BALL_S || nx > X_MAX - BALL_S || ny < BALL_S || ny > Y_MAX - BALL_S) begin
              m_on[n] = 0;
              m_lock[n] = COOLDOWN;
            end else begin
              m_x[n] = nx;
              m_y[n] = ny;
            end
          end else if (m_lock[n] > 0) begin
            m_lock[n]--;
          end else if (launch) begin
            m_on[n] = 1; m_x[n] = tx[n]; m_y[n] = ty[n]; m_dir[n] = dr[n];
          end
        end
      end
    end
  end

  always @(negedge Clk) begin
    if (cmp_en) begin
      check("m_BallX1", int'(BallX1), m_x[0]);
      check("m_BallY1", int'(BallY1), m_y[0]);
      check("m_BallX2", int'(BallX2), m_x[1]);
      check("m_BallY2", int'(BallY2), m_y[1]);
      check("m_ball_fire1", int'(ball_fire1), m_on[0]);
      check("m_ball_fire2", int'(ball_fire2), m_on[1]);
      check("m_hit1", int'(hit1), m_struck[0]);
      check("m_hit2", int'(hit2), m_struck[1]);
      check("m_score1", int'(score1), m_score[0]);
      check("m_score2", int'(score2), m_score[1]);
    end
  end

  task automatic do_tick();
    @(posedge Clk); #2 frame_clk = 1'b1;
    @(posedge Clk); #2 frame_clk = 1'b0;
  endtask

  task automatic do_reset();
    fire1 = 1'b0; fire2 = 1'b0; Reset = 1'b1;
    @(posedge Clk); #2;
    @(posedge Clk); #2 Reset = 1'b0;
  endtask

  task automatic place(input int x1, input int y1, input int d1, input int x2, input int y2, input int d2);
    TankX1 = 10'(x1); TankY1 = 10'(y1); dir1 = 2'(d1);
    TankX2 = 10'(x2); TankY2 = 10'(y2); dir2 = 2'(d2);
  endtask

  initial begin
    Reset = 1'b1; frame_clk = 1'b0; fire1 = 1'b0; fire2 = 1'b0;
    place(0, 0, 0, 0, 0, 0);
    @(posedge Clk); #2 cmp_en = 1'b1;
    repeat (2) @(posedge Clk);
    #2 Reset = 1'b0;
    check("rst_ball_fire1", int'(ball_fire1), 0);
    check("rst_ball_fire2", int'(ball_fire2), 0);
    check("rst_BallX1", int'(BallX1), 0);
    check("rst_score2", int'(score2), 0);

    // launch and first step
    place(100, 100, 1, 500, 400, 0);
    fire1 = 1'b1; do_tick();
    check("launch_fire1", int'(ball_fire1), 1);
    check("launch_X1", int'(BallX1), 100);
    check("launch_Y1", int'(BallY1), 100);
    do_tick();
    check("move_X1", int'(BallX1), 104);
    check("move_Y1", int'(BallY1), 100);
    do_reset();

    // right-wall exit, then launch attempt during lockout
    place(630, 240, 1, 100, 400, 0);
    fire1 = 1'b1; do_tick();
    check("wall_launch_X1", int'(BallX1), 630);
    do_tick();
    check("wall_step_X1", int'(BallX1), 634);
    do_tick();
    check("wall_exit_fire1", int'(ball_fire1), 0);
    check("wall_hold_X1", int'(BallX1), 634);
    check("wall_score1", int'(score1), 0);
    fire1 = 1'b0; do_tick();
    fire1 = 1'b1; do_tick();
    check("wall_cool_nolaunch", int'(ball_fire1), 0);
    do_reset();

    // hit on the 8th tick after launch
    place(100, 200, 1, 140, 200, 0);
    fire1 = 1'b1; do_tick();
    check("hit_launch_X1", int'(BallX1), 100);
    for (int i = 1; i <= 7; i++) begin
      do_tick();
      check("hit_fly_X1", int'(BallX1), 100 + 4 * i);
    end
    do_tick();
    check("hit_hit2", int'(hit2), 1);
    check("hit_hit1", int'(hit1), 0);
    check("hit_score1", int'(score1), 1);
    check("hit_fire1", int'(ball_fire1), 0);
    @(posedge Clk); #2;
    check("hit_pulse_end", int'(hit2), 0);

    // lockout with fire toggled every other tick, then edge-only relaunch
    for (int t = 1; t <= 31; t++) begin
      fire1 = (t % 2 == 0); do_tick();
      check("cool_nolaunch", int'(ball_fire1), 0);
    end
    fire1 = 1'b1; do_tick();
    check("cool_relaunch", int'(ball_fire1), 1);
    repeat (8) do_tick();
    check("cool_score1", int'(score1), 2);
    for (int t = 0; t < 45; t++) begin
      do_tick();
      check("held_nolaunch", int'(ball_fire1), 0);
    end
    do_reset();

    // simultaneous hits and score saturation
    place(100, 200, 1, 140, 200, 3);
    fire1 = 1'b1; fire2 = 1'b1; do_tick();
    repeat (7) do_tick();
    do_tick();
    check("dual_hit1", int'(hit1), 1);
    check("dual_hit2", int'(hit2), 1);
    check("dual_score1", int'(score1), 1);
    check("dual_score2", int'(score2), 1);
    for (int r = 0; r < 15; r++) begin
      fire1 = 1'b0; fire2 = 1'b0;
      repeat (31) do_tick();
      fire1 = 1'b1; fire2 = 1'b1; do_tick();
      repeat (7) do_tick();
      do_tick();
      check("sat_hit1", int'(hit1), 1);
      check("sat_score1", int'(score1), (r + 2 > 15) ? 15 : r + 2);
    end
    check("sat_final1", int'(score1), 15);
    check("sat_final2", int'(score2), 15);
    do_reset();

    // reset mid-flight
    place(500, 400, 1, 300, 300, 0);
    fire2 = 1'b1; do_tick();
    check("rmf_launch2", int'(ball_fire2), 1);
    do_tick();
    check("rmf_step_Y2", int'(BallY2), 296);
    Reset = 1'b1;
    @(posedge Clk); #2;
    check("rmf_fire2", int'(ball_fire2), 0);
    check("rmf_X2", int'(BallX2), 0);
    check("rmf_Y2", int'(BallY2), 0);
    Reset = 1'b0; fire2 = 1'b0; do_tick();
    fire2 = 1'b1; do_tick();
    check("rmf_relaunch2", int'(ball_fire2), 1);
    check("rmf_relaunch_X2", int'(BallX2), 300);
    check("rmf_relaunch_Y2", int'(BallY2), 300);

    // randomized run, checked against the model every cycle
    for (int c = 0; c < 8000; c++) begin
      @(posedge Clk); #2;
      frame_clk = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 7) == 0) fire1 = ~fire1;
      if ($urandom_range(0, 7) == 0) fire2 = ~fire2;
      if ($urandom_range(0, 31) == 0) dir1 = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 31) == 0) dir2 = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 199) == 0) begin
        int x1, y1, x2, y2;
        x1 = int'($urandom_range(0, X_MAX));
        y1 = int'($urandom_range(0, Y_MAX));
        x2 = x1 + int'($urandom_range(0, 80)) - 40;
        y2 = y1 + int'($urandom_range(0, 80)) - 40;
        x2 = (x2 < 0) ? 0 : (x2 > X_MAX) ? X_MAX : x2;
        y2 = (y2 < 0) ? 0 : (y2 > Y_MAX) ? Y_MAX : y2;
        place(x1, y1, int'(dir1), x2, y2, int'(dir2));
      end
      Reset = ($urandom_range(0, 999) == 0);
    end
    @(posedge Clk); #2 Reset = 1'b0;
    @(posedge Clk); #2;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
